// File: rtl/amp_shdn_ctrl.sv
// amp_shdn_ctrl: power/fault sequencer for NUM_AMP class-D amplifier channels
//   clk, rst_n : 50 MHz clock, asynchronous active-low reset (already synchronised)
//   Flt_n      : raw asynchronous amp fault pins, active low
//   seq_low    : EQ low-frequency queues primed (level)
//   clr_lock   : single-cycle pulse that leaves lockout once faults are clear
//   sht_dwn    : amp shutdown, active high, registered
//   flt_src    : sticky set of amps whose debounced faults caused the last shutdown
//   retry_cnt  : consecutive-fault count
//   locked     : high while locked out
//   gain       : soft-start gain for speaker drive scaling
// Optional macro SOFT_START_EN builds the gain ramp; otherwise gain is a constant 8'hFF.
module amp_shdn_ctrl #(
  parameter int NUM_AMP   = 2,
  parameter int DBNC_CYC  = 1024,
  parameter int RETRY_CYC = 50000000,
  parameter int MAX_RETRY = 3,
  parameter int RAMP_STEP = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_AMP-1:0] Flt_n,
  input  logic               seq_low,
  input  logic               clr_lock,
  output logic [NUM_AMP-1:0] sht_dwn,
  output logic [NUM_AMP-1:0] flt_src,
  output logic [3:0]         retry_cnt,
  output logic               locked,
  output logic [7:0]         gain
);
  localparam int DW = $clog2(DBNC_CYC + 1);
  localparam int TW = $clog2(RETRY_CYC + 1);
  typedef enum logic [2:0] {WAIT, RUN, FAULT, FAULT_HOLD, LOCKOUT} state_t;
  state_t state, nxt;
  logic [NUM_AMP-1:0] sync1, sync2, flt_db, flt_src_nxt;
  logic [NUM_AMP-1:0][DW-1:0] dbnc;
  logic [TW-1:0] timer, timer_nxt;
  logic [3:0] retry_nxt;
  logic flt_any;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync2, sync1} <= '0;
    else {sync2, sync1} <= {sync1, Flt_n};
  for (genvar i = 0; i < NUM_AMP; i++) begin : g_dbnc
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dbnc[i] <= '0;
      else if (sync2[i]) dbnc[i] <= '0;
      else if (dbnc[i] != DW'(DBNC_CYC)) dbnc[i] <= dbnc[i] + 1'b1;
    assign flt_db[i] = dbnc[i] == DW'(DBNC_CYC);
  end
  assign flt_any = |flt_db;
  // The shared timer counts fault-free RUN cycles or FAULT_HOLD cycles and restarts on every state change.
  always_comb begin
    nxt         = state;
    timer_nxt   = '0;
    retry_nxt   = retry_cnt;
    flt_src_nxt = flt_src;
    case (state)
      WAIT: nxt = flt_any ? FAULT : seq_low ? RUN : WAIT;
      RUN: begin
        nxt       = flt_any ? FAULT : RUN;
        timer_nxt = (timer == TW'(RETRY_CYC)) ? timer : timer + 1'b1;
        if (!flt_any && timer >= TW'(RETRY_CYC - 1)) retry_nxt = '0;
      end
      FAULT: begin
        flt_src_nxt = flt_db;
        retry_nxt   = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
        nxt         = ({1'b0, retry_cnt} + 5'd1 >= 5'(MAX_RETRY)) ? LOCKOUT : FAULT_HOLD;
      end
      FAULT_HOLD:
        if (!flt_any) begin
          if (timer == TW'(RETRY_CYC - 1)) nxt = WAIT;
          else timer_nxt = timer + 1'b1;
        end
      LOCKOUT:
        if (clr_lock && !flt_any) begin
          nxt       = WAIT;
          retry_nxt = '0;
        end
      default: nxt = WAIT;
    endcase
    if (nxt != state) timer_nxt = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= WAIT;
      timer     <= '0;
      retry_cnt <= '0;
      flt_src   <= '0;
      sht_dwn   <= '1;
      locked    <= 1'b0;
    end else begin
      state     <= nxt;
      timer     <= timer_nxt;
      retry_cnt <= retry_nxt;
      flt_src   <= flt_src_nxt;
      sht_dwn   <= {NUM_AMP{nxt != RUN}};
      locked    <= nxt == LOCKOUT;
    end
`ifdef SOFT_START_EN
  localparam int RW = $clog2(RAMP_STEP + 1);
  logic [RW-1:0] ramp;
  // Gain is zeroed on the same edge sht_dwn rises and restarts from 0 on every RUN entry.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gain <= '0;
      ramp <= '0;
    end else if (nxt != RUN || state != RUN) begin
      gain <= '0;
      ramp <= '0;
    end else if (ramp == RW'(RAMP_STEP - 1)) begin
      ramp <= '0;
      gain <= (gain == 8'hFF) ? gain : gain + 8'd1;
    end else ramp <= ramp + 1'b1;
`else
  assign gain = 8'hFF;
`endif
endmodule

// File: tb/tb_amp_shdn_ctrl.sv
// tb_amp_shdn_ctrl: scoreboard bench for amp_shdn_ctrl with directed fault/lockout/reset vectors
module tb_amp_shdn_ctrl;
  localparam int SHT = 0, SRC = 1, RET = 2, LCK = 3, GN = 4;
`ifdef SOFT_START_EN
  localparam int GAIN_RST = 0;
`else
  localparam int GAIN_RST = 255;
`endif
  logic clk = 0, rst_n = 1, seq_low = 0, clr_lock = 0;
  logic [1:0] Flt_n = 2'b11;
  logic [1:0] sht_dwn, flt_src;
  logic [3:0] retry_cnt;
  logic locked;
  logic [7:0] gain;
  amp_shdn_ctrl #(.NUM_AMP(2), .DBNC_CYC(4), .RETRY_CYC(20), .MAX_RETRY(3), .RAMP_STEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .Flt_n(Flt_n), .seq_low(seq_low), .clr_lock(clr_lock),
    .sht_dwn(sht_dwn), .flt_src(flt_src), .retry_cnt(retry_cnt), .locked(locked), .gain(gain)
  );
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int    at;
    int    sel;
    int    val;
    string nm;
  } exp_t;
  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  function automatic logic [31:0] obs(input int sel);
    return sel == SHT ? 32'(sht_dwn) : sel == SRC ? 32'(flt_src) : sel == RET ? 32'(retry_cnt) :
           sel == LCK ? 32'(locked) : 32'(gain);
  endfunction
  task automatic exp_at(input int dc, input int sel, input int val, input string nm);
    exp_t e;
    e.at = cyc + dc; e.sel = sel; e.val = val; e.nm = nm;
    q.push_back(e);
  endtask
  always @(negedge clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].at == cyc) begin
        n_tests++;
        if (obs(q[i].sel) !== 32'(q[i].val)) begin
          n_fail++;
          $display("FAIL %s at cycle %0d: got %0d, expected %0d", q[i].nm, cyc, obs(q[i].sel), q[i].val);
        end
        q.delete(i);
      end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic reset_checks(input int dc);
    exp_at(dc, SHT, 3, "rst_sht");
    exp_at(dc, SRC, 0, "rst_src");
    exp_at(dc, RET, 0, "rst_retry");
    exp_at(dc, LCK, 0, "rst_locked");
    exp_at(dc, GN, GAIN_RST, "rst_gain");
  endtask
  task automatic start_fault(input logic [1:0] f, input int src, input int ret, input int lock);
    Flt_n = f;
    exp_at(6, SHT, 0, "pre_fault_sht");
    exp_at(7, SHT, 3, "fault_sht");
    exp_at(8, SRC, src, "fault_src");
    exp_at(8, RET, ret, "fault_retry");
    exp_at(8, LCK, lock, "fault_locked");
    exp_at(7, GN, GAIN_RST, "fault_gain");
  endtask
  task automatic release_and_rerun();
    Flt_n = 2'b11;
    exp_at(23, SHT, 3, "hold_sht");
    exp_at(24, SHT, 0, "rerun_sht");
    tick(24);
  endtask
  initial begin
    #1 rst_n = 0;
    tick(1);
    reset_checks(1);
    tick(2);
    rst_n = 1;
    tick(6);
    exp_at(1, SHT, 3, "wait_sht");
    tick(1);
    seq_low = 1;
    exp_at(1, SHT, 0, "run_sht");
    exp_at(1, RET, 0, "run_retry");
`ifdef SOFT_START_EN
    exp_at(1, GN, 0, "ramp0");
    exp_at(2, GN, 0, "ramp0b");
    exp_at(3, GN, 1, "ramp1");
    exp_at(5, GN, 2, "ramp2");
`else
    exp_at(1, GN, 255, "gain_const");
`endif
    tick(6);
    Flt_n = 2'b01;
    for (int d = 1; d <= 12; d++) exp_at(d, SHT, 0, "glitch_sht");
    exp_at(12, SRC, 0, "glitch_src");
    tick(3);
    Flt_n = 2'b11;
    tick(12);
    start_fault(2'b10, 1, 1, 0);
    tick(10);
    release_and_rerun();
    exp_at(19, RET, 1, "retry_held");
    exp_at(20, RET, 0, "retry_clr");
    tick(22);
    start_fault(2'b10, 1, 1, 0);
    tick(10);
    release_and_rerun();
    tick(2);
    start_fault(2'b01, 2, 2, 0);
    tick(10);
    release_and_rerun();
    tick(2);
    start_fault(2'b10, 1, 3, 1);
    tick(12);
    clr_lock = 1;
    tick(1);
    clr_lock = 0;
    exp_at(1, LCK, 1, "clr_ignored");
    tick(2);
    Flt_n = 2'b11;
    exp_at(5, SHT, 3, "lock_sht");
    exp_at(5, LCK, 1, "lock_held");
    exp_at(5, RET, 3, "lock_retry");
    tick(10);
    clr_lock = 1;
    exp_at(1, LCK, 0, "unlock");
    exp_at(1, RET, 0, "unlock_retry");
    exp_at(1, SHT, 3, "unlock_wait_sht");
    exp_at(2, SHT, 0, "unlock_run");
    tick(1);
    clr_lock = 0;
    tick(520);
    exp_at(6, GN, 255, "gain_sat");
    start_fault(2'b01, 2, 1, 0);
    tick(10);
    Flt_n = 2'b11;
    tick(5);
    rst_n = 0;
    seq_low = 0;
    tick(2);
    rst_n = 1;
    tick(3);
    Flt_n = 2'b00;
    exp_at(6, SHT, 3, "prio_wait_sht");
    exp_at(7, SHT, 3, "prio_sht");
    exp_at(8, SRC, 3, "prio_src");
    exp_at(8, RET, 1, "prio_retry");
    tick(6);
    seq_low = 1;
    tick(5);
    @(posedge clk);
    #2 rst_n = 0;
    reset_checks(0);
    #1;
    n_tests++;
    if (sht_dwn !== 2'b11) begin
      n_fail++;
      $display("FAIL async_rst_sht: got %0d", sht_dwn);
    end
    n_tests++;
    if (flt_src !== 2'b00) begin
      n_fail++;
      $display("FAIL async_rst_src: got %0d", flt_src);
    end
    n_tests++;
    if (retry_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_rst_retry: got %0d", retry_cnt);
    end
    n_tests++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst_locked: got %0d", locked);
    end
    Flt_n = 2'b11;
    seq_low = 0;
    tick(3);
    rst_n = 1;
    tick(3);
    foreach (q[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d never checked", q[i].nm, q[i].at);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
